// File: rtl/flash_range_erase_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : flash_range_erase_ctrl                                        |
// | Purpose  : Sequential page/bank/range erase controller with busy/done    |
// |            handshake, abort-on-error and failing-page reporting.         |
// | Options  : FLASH_ERASE_RETRY_EN - re-request a failing page once.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module flash_range_erase_ctrl #(
    parameter  int Banks        = 2,
    parameter  int PagesPerBank = 256,
    parameter  int WordsPerPage = 256,
    parameter  int CntW         = 8,
    localparam int WordsW       = $clog2(WordsPerPage),
    localparam int PagesW       = $clog2(PagesPerBank),
    localparam int BankW        = (Banks > 1) ? $clog2(Banks) : 1,
    localparam int AddrW        = $clog2(Banks * PagesPerBank * WordsPerPage),
    localparam int TotalPages   = Banks * PagesPerBank
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             op_start_i,
    input  logic [1:0]       op_type_i,
    input  logic [AddrW-1:0] op_addr_i,
    input  logic [CntW-1:0]  op_num_pages_i,
    output logic             op_busy_o,
    output logic             op_done_o,
    output logic             op_err_o,
    output logic [AddrW-1:0] op_err_addr_o,
    output logic             flash_req_o,
    output logic [AddrW-1:0] flash_addr_o,
    output logic             flash_op_o,
    input  logic             flash_done_i,
    input  logic             flash_error_i
);

    // Page index sum is one bit wider than either operand so the range
    // check cannot wrap.
    localparam int PageIdxW = BankW + PagesW;
    localparam int SumW     = ((PageIdxW > CntW) ? PageIdxW : CntW) + 1;

    localparam logic [1:0] c_type_page  = 2'd0;
    localparam logic [1:0] c_type_bank  = 2'd1;
    localparam logic [1:0] c_type_range = 2'd2;
    localparam logic [1:0] c_type_bad   = 2'd3;

    localparam logic [AddrW-1:0] c_page_mask = ~AddrW'(WordsPerPage - 1);
    localparam logic [AddrW-1:0] c_bank_mask = ~AddrW'(PagesPerBank * WordsPerPage - 1);
    localparam logic [AddrW-1:0] c_page_step = AddrW'(WordsPerPage);
    localparam logic [SumW-1:0]  c_total_pg  = SumW'(TotalPages);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_bank_op;
    logic [AddrW-1:0]  r_addr;
    logic [CntW-1:0]   r_remaining;
    logic              r_err_flag;
    logic [AddrW-1:0]  r_err_addr;

    logic [AddrW-1:0]  w_page_addr;
    logic [AddrW-1:0]  w_start_addr;
    logic [SumW-1:0]   w_last_page;
    logic              w_start_bad;
    logic              w_retry_ok;

`ifdef FLASH_ERASE_RETRY_EN
    logic              r_retried;
    assign w_retry_ok = ~r_retried;
`else
    assign w_retry_ok = 1'b0;
`endif

    assign w_page_addr  = op_addr_i & c_page_mask;
    assign w_start_addr = (op_type_i == c_type_bank) ? (op_addr_i & c_bank_mask) : w_page_addr;
    assign w_last_page  = SumW'(op_addr_i[AddrW-1:WordsW]) + SumW'(op_num_pages_i);
    assign w_start_bad  = (op_type_i == c_type_bad) ||
                          ((op_type_i == c_type_range) && (w_last_page >= c_total_pg));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (op_start_i) begin
                    w_next_state = w_start_bad ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (flash_done_i) begin
                    if (flash_error_i) begin
                        w_next_state = w_retry_ok ? ST_GAP : ST_DONE;
                    end else if (r_remaining == '0) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_GAP;
                    end
                end
            end
            ST_GAP:  w_next_state = ST_REQ;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bank_op   <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_err_flag  <= 1'b0;
            r_err_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_start_i) begin
                        r_bank_op   <= (op_type_i == c_type_bank);
                        r_addr      <= w_start_addr;
                        r_remaining <= (op_type_i == c_type_range) ? op_num_pages_i : '0;
                        r_err_flag  <= w_start_bad;
                        r_err_addr  <= w_start_bad ? w_page_addr : '0;
                    end
                end
                ST_REQ: begin
                    if (flash_done_i) begin
                        if (flash_error_i) begin
                            // A retryable failure keeps address and count so the
                            // GAP cycle leads straight back to the same page.
                            if (!w_retry_ok) begin
                                r_err_flag <= 1'b1;
                                r_err_addr <= r_addr;
                            end
                        end else if (r_remaining != '0) begin
                            r_remaining <= r_remaining - CntW'(1);
                            r_addr      <= r_addr + c_page_step;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FLASH_ERASE_RETRY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_retried <= 1'b0;
        end else if ((r_state == ST_IDLE) && op_start_i) begin
            r_retried <= 1'b0;
        end else if ((r_state == ST_REQ) && flash_done_i) begin
            r_retried <= flash_error_i;
        end
    end
`endif

    assign op_busy_o     = (r_state != ST_IDLE);
    assign op_done_o     = (r_state == ST_DONE);
    assign op_err_o      = (r_state == ST_DONE) && r_err_flag;
    assign op_err_addr_o = r_err_addr;
    assign flash_req_o   = (r_state == ST_REQ);
    assign flash_addr_o  = r_addr;
    assign flash_op_o    = r_bank_op;

endmodule

`default_nettype wire

// File: tb/tb_flash_range_erase_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_flash_range_erase_ctrl                                     |
// | Purpose  : Scoreboard bench for flash_range_erase_ctrl (default geometry)|
// |            Honours FLASH_ERASE_RETRY_EN when defined.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_flash_range_erase_ctrl;

    localparam int AW    = 17;
    localparam int WPP   = 256;
    localparam int PPB   = 256;
    localparam int TOTAL = 512;
`ifdef FLASH_ERASE_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          op_start_i;
    logic [1:0]    op_type_i;
    logic [AW-1:0] op_addr_i;
    logic [7:0]    op_num_pages_i;
    logic          op_busy_o;
    logic          op_done_o;
    logic          op_err_o;
    logic [AW-1:0] op_err_addr_o;
    logic          flash_req_o;
    logic [AW-1:0] flash_addr_o;
    logic          flash_op_o;
    logic          flash_done_i;
    logic          flash_error_i;

    flash_range_erase_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .op_start_i     (op_start_i),
        .op_type_i      (op_type_i),
        .op_addr_i      (op_addr_i),
        .op_num_pages_i (op_num_pages_i),
        .op_busy_o      (op_busy_o),
        .op_done_o      (op_done_o),
        .op_err_o       (op_err_o),
        .op_err_addr_o  (op_err_addr_o),
        .flash_req_o    (flash_req_o),
        .flash_addr_o   (flash_addr_o),
        .flash_op_o     (flash_op_o),
        .flash_done_i   (flash_done_i),
        .flash_error_i  (flash_error_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic err; logic [AW-1:0] addr; } done_t;
    typedef struct packed { logic op;  logic [AW-1:0] addr; } req_t;

    done_t exp_done_q[$];
    req_t  exp_req_q[$];
    bit    resp_q[$];

    int tests = 0;
    int fails = 0;
    bit stall = 1'b0;
    int lat   = 3;
    bit post1 = 1'b0;
    bit post2 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: expand an operation into its flash request list and result.
    task automatic model(input int typ, input int addr, input int num,
                         input int ffirst, input int fretry);
        int  sp = addr / WPP;
        int  npages;
        int  a;
        bit  e;
        done_t d;
        req_t  r;
        if (typ == 3 || (typ == 2 && sp + num >= TOTAL)) begin
            d.err = 1'b1; d.addr = AW'(sp * WPP);
            exp_done_q.push_back(d);
            return;
        end
        npages = (typ == 2) ? num + 1 : 1;
        for (int i = 0; i < npages; i++) begin
            a = (typ == 1) ? (addr / (PPB * WPP)) * (PPB * WPP) : (sp + i) * WPP;
            r.op = (typ == 1); r.addr = AW'(a);
            e = (i < 32) ? ffirst[i] : 1'b0;
            exp_req_q.push_back(r); resp_q.push_back(e);
            if (e && RETRY) begin
                e = (i < 32) ? fretry[i] : 1'b0;
                exp_req_q.push_back(r); resp_q.push_back(e);
            end
            if (e) begin
                d.err = 1'b1; d.addr = AW'(a);
                exp_done_q.push_back(d);
                return;
            end
        end
        d.err = 1'b0; d.addr = '0;
        exp_done_q.push_back(d);
    endtask

    // Flash responder: answers requests after a random latency and checks
    // the address/op and the one-cycle gap between consecutive requests.
    initial begin
        req_t r;
        bit   e;
        flash_done_i  = 1'b0;
        flash_error_i = 1'b0;
        forever begin
            @(negedge clk_i);
            flash_done_i  = 1'b0;
            flash_error_i = 1'b0;
            if (rst_i) begin
                post1 = 1'b0;
                post2 = 1'b0;
            end else begin
                if (post2) begin
                    post2 = 1'b0;
                    if (exp_req_q.size() > 0) check("gap_then_req", flash_req_o, 1);
                end
                if (post1) begin
                    post1 = 1'b0;
                    post2 = 1'b1;
                    check("req_drop", flash_req_o, 0);
                end else if (flash_req_o && !stall) begin
                    if (lat > 0) begin
                        lat--;
                    end else begin
                        if (exp_req_q.size() == 0) begin
                            check("unexpected_req", flash_addr_o, 64'hFFFF_FFFF);
                            e = 1'b0;
                        end else begin
                            r = exp_req_q.pop_front();
                            e = resp_q.pop_front();
                            check("req_addr", flash_addr_o, r.addr);
                            check("req_op", flash_op_o, r.op);
                        end
                        flash_done_i  = 1'b1;
                        flash_error_i = e;
                        lat   = $urandom_range(0, 3);
                        post1 = 1'b1;
                    end
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        done_t d;
        forever begin
            @(negedge clk_i);
            if (!rst_i && op_done_o) begin
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", op_done_o, 0);
                end else begin
                    d = exp_done_q.pop_front();
                    check("done_err", op_err_o, d.err);
                    if (d.err) check("err_addr", op_err_addr_o, d.addr);
                    check("reqs_outstanding", exp_req_q.size(), 0);
                end
            end
        end
    end

    task automatic run_op(input int typ, input int addr, input int num,
                          input int ffirst, input int fretry, input bit poke);
        bit bad = (typ == 3) || (typ == 2 && addr / WPP + num >= TOTAL);
        int t = 0;
        model(typ, addr, num, ffirst, fretry);
        op_type_i      = 2'(typ);
        op_addr_i      = AW'(addr);
        op_num_pages_i = 8'(num);
        op_start_i     = 1'b1;
        @(negedge clk_i);
        op_start_i = 1'b0;
        if (bad) check("illegal_first_cycle", {op_done_o, op_err_o, flash_req_o}, 3'b110);
        else     check("start_busy_req", {op_busy_o, flash_req_o}, 2'b11);
        while (!op_done_o && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        if (!op_done_o) begin
            check("done_timeout", op_done_o, 1);
            exp_done_q.delete(); exp_req_q.delete(); resp_q.delete();
        end
        check("busy_in_done", op_busy_o, 1);
        if (poke) begin
            op_type_i  = 2'd0;
            op_addr_i  = AW'(17'h00500);
            op_start_i = 1'b1;
        end
        @(negedge clk_i);
        op_start_i = 1'b0;
        check("idle_after_done", op_busy_o, 0);
    endtask

    function automatic int rand_mask(input int one_in);
        int m = 0;
        for (int i = 0; i < 8; i++) if ($urandom_range(1, one_in) == 1) m |= (1 << i);
        return m;
    endfunction

    initial begin
        int typ, addr, num;
        rst_i = 1'b1; op_start_i = 1'b0; op_type_i = '0; op_addr_i = '0; op_num_pages_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset_outputs", {op_busy_o, op_done_o, op_err_o, flash_req_o, flash_op_o,
                                op_err_addr_o, flash_addr_o}, 64'd0);
        rst_i = 1'b0;

        run_op(0, 32'h1234F, 0, 0, 0, 1'b0);
        run_op(1, 32'h1ABCD, 0, 0, 0, 1'b0);
        run_op(2, 32'h0FE00, 3, 0, 0, 1'b0);
        run_op(2, 32'h1FE00, 5, 0, 0, 1'b0);
        run_op(2, 32'h04000, 3, 32'h2, 32'h0, 1'b0);
        run_op(2, 32'h05000, 3, 32'h2, 32'h2, 1'b0);
        run_op(3, 32'h0ABCD, 0, 0, 0, 1'b0);
        run_op(2, 508 * WPP, 3, 0, 0, 1'b0);
        run_op(2, 508 * WPP + 8'h7F, 4, 0, 0, 1'b0);
        run_op(1, 32'h0FFFF, 0, 32'h1, 32'h1, 1'b0);

        // Reset while a request is pending: nothing completes, all outputs clear.
        stall          = 1'b1;
        op_type_i      = 2'd2;
        op_addr_i      = AW'(17'h02000);
        op_num_pages_i = 8'd3;
        op_start_i     = 1'b1;
        @(negedge clk_i);
        op_start_i = 1'b0;
        check("mid_req_pending", flash_req_o, 1);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("reset_mid_req", {op_busy_o, op_done_o, op_err_o, flash_req_o, flash_op_o,
                                op_err_addr_o, flash_addr_o}, 64'd0);
        repeat (3) @(negedge clk_i);
        check("no_req_after_reset", {op_busy_o, flash_req_o}, 2'b00);
        stall = 1'b0;

        run_op(0, 32'h00321, 0, 0, 0, 1'b1);
        run_op(0, 32'h00777, 0, 0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            typ  = ($urandom_range(0, 9) < 6) ? 2 : $urandom_range(0, 3);
            addr = $urandom_range(0, (1 << AW) - 1);
            if ($urandom_range(0, 3) == 0) addr = $urandom_range(504 * WPP, (1 << AW) - 1);
            num  = $urandom_range(0, 7);
            run_op(typ, addr, num, rand_mask(6), rand_mask(2), ($urandom_range(0, 4) == 0));
        end

        repeat (3) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
